// File: rtl/fp_pkg.sv
// Shared definitions for the sequential floating-point add/subtract unit.
// Holds FSM state codes, flag bit positions, operand class codes and the
// canonical quiet-NaN builder used by the top level.
package fp_pkg;

  // FSM state encoding: one registered datapath stage per state
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ALIGN = 3'd1;
  localparam logic [2:0] ST_ADD   = 3'd2;
  localparam logic [2:0] ST_NORM  = 3'd3;
  localparam logic [2:0] ST_ROUND = 3'd4;
  localparam logic [2:0] ST_OUT   = 3'd5;

  // Bit positions inside the {N,Z,C,V} flag vector
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  // Operand / result class codes
  localparam logic [1:0] CLS_ZERO = 2'd0;
  localparam logic [1:0] CLS_NORM = 2'd1;
  localparam logic [1:0] CLS_INF  = 2'd2;
  localparam logic [1:0] CLS_NAN  = 2'd3;

  // Canonical quiet NaN {0, all-ones exponent, 1, 0...}, right-aligned in 64 bits
  function automatic logic [63:0] qnan(input int exp_w, input int man_w);
    logic [63:0] v;
    v = '0;
    for (int i = 0; i < exp_w; i++) v[man_w + i] = 1'b1;
    v[man_w - 1] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/fp_addsub_seq_lzc.sv
// Combinational leading-zero counter used to normalise after cancellation.
// Ports: din (WIDTH bits) in, cnt out = number of leading zeros (WIDTH when din is 0).
// Latency: zero cycles (pure combinational); no flow control.
module fp_lzc #(
  parameter int WIDTH = 27
) (
  input  logic [WIDTH-1:0]               din,
  output logic [$clog2(WIDTH+1)-1:0]     cnt
);
  localparam int CW = $clog2(WIDTH + 1);

  // Highest set bit wins because later loop iterations overwrite earlier ones
  always_comb begin
    cnt = CW'(WIDTH);
    for (int i = 0; i < WIDTH; i++) begin
      if (din[i]) cnt = CW'(WIDTH - 1 - i);
    end
  end
endmodule

// File: rtl/fp_addsub_seq.sv
// Sequential IEEE-754 add/subtract, round-to-nearest-even, FTZ, specials, {N,Z,C,V} flags.
// Latency: result valid 4 edges after the accept edge (5th edge counting the accept); one op in flight.
// Backpressure: result/flags held in OUT until out_ready; in_ready only in IDLE, busy in_valid ignored.
// Ports: clk, reset_n (async low); in_valid/in_ready/op_sub/a/b request side;
//        out_valid/out_ready/result/flags response side.
module fp_addsub_seq
  import fp_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   op_sub,
  input  logic [EXP_W+MAN_W:0]   a,
  input  logic [EXP_W+MAN_W:0]   b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   result,
  output logic [3:0]             flags
);
  localparam int W   = 1 + EXP_W + MAN_W;
  localparam int MW  = MAN_W + 4;            // hidden, fraction, G, R, S
  localparam int EW  = EXP_W + 2;            // signed working exponent
  localparam int LZW = $clog2(MW + 1);
  localparam logic [EXP_W-1:0]       EXP_MAX  = '1;
  localparam logic signed [EW-1:0]   EXP_INF  = {2'b00, EXP_MAX};
  localparam logic signed [EW-1:0]   ONE_S    = 1;
  localparam logic [63:0]            QNAN_ALL = qnan(EXP_W, MAN_W);

  function automatic logic [1:0] classify(input logic [EXP_W-1:0] e, input logic [MAN_W-1:0] f);
    if (e == '0)           return CLS_ZERO;    // subnormals flushed to zero
    else if (e != EXP_MAX) return CLS_NORM;
    else if (f == '0)      return CLS_INF;
    else                   return CLS_NAN;
  endfunction

  logic [2:0]              state_q, state_d;
  logic [W-1:0]            a_q, b_q;
  logic [1:0]              spec_q;
  logic                    spec_sign_q, sx_q, sy_q, carry_q, zero_q, rsign_q;
  logic signed [EW-1:0]    ex_q;
  logic [MW-1:0]           mx_q, my_q, mn_q;
  logic [MW:0]             sum_q;
  logic [W-1:0]            result_q;
  logic [3:0]              flags_q;

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_OUT);
  assign result    = result_q;
  assign flags     = flags_q;

  // ---------------- ALIGN: classify, order by magnitude, shift smaller operand
  logic [1:0]         ca, cb;
  logic [W-2:0]       mag_a, mag_b;
  logic               a_ge_b, sa, sb, nan_d, inf_d;
  logic [EXP_W-1:0]   xe, ye, diff, sh;
  logic [MAN_W:0]     xm, ym;
  logic [2*MW-1:0]    wide;
  logic [MW-1:0]      my_d;
  logic [1:0]         spec_d;

  always_comb begin
    ca     = classify(a_q[W-2 -: EXP_W], a_q[MAN_W-1:0]);
    cb     = classify(b_q[W-2 -: EXP_W], b_q[MAN_W-1:0]);
    sa     = a_q[W-1];
    sb     = b_q[W-1];
    mag_a  = (ca == CLS_ZERO) ? '0 : a_q[W-2:0];
    mag_b  = (cb == CLS_ZERO) ? '0 : b_q[W-2:0];
    a_ge_b = (mag_a >= mag_b);
    xe     = a_ge_b ? mag_a[W-2 -: EXP_W] : mag_b[W-2 -: EXP_W];
    ye     = a_ge_b ? mag_b[W-2 -: EXP_W] : mag_a[W-2 -: EXP_W];
    xm     = a_ge_b ? {(ca != CLS_ZERO), mag_a[MAN_W-1:0]} : {(cb != CLS_ZERO), mag_b[MAN_W-1:0]};
    ym     = a_ge_b ? {(cb != CLS_ZERO), mag_b[MAN_W-1:0]} : {(ca != CLS_ZERO), mag_a[MAN_W-1:0]};
    diff   = xe - ye;
    // Clamping at MW pushes the whole of y into the sticky region
    sh     = (diff > EXP_W'(MW)) ? EXP_W'(MW) : diff;
    wide   = {ym, 3'b000, {MW{1'b0}}} >> sh;
    my_d   = {wide[2*MW-1:MW+1], wide[MW] | (|wide[MW-1:0])};
    nan_d  = (ca == CLS_NAN) || (cb == CLS_NAN) ||
             ((ca == CLS_INF) && (cb == CLS_INF) && (sa != sb));
    inf_d  = (ca == CLS_INF) || (cb == CLS_INF);
    spec_d = nan_d ? CLS_NAN : (inf_d ? CLS_INF : CLS_NORM);
  end

  // ---------------- ADD
  logic [MW:0] sum_d;
  always_comb begin
    if (sx_q ^ sy_q) sum_d = {1'b0, mx_q} - {1'b0, my_q};   // x >= y, never negative
    else             sum_d = {1'b0, mx_q} + {1'b0, my_q};
  end

  // ---------------- NORM
  logic [LZW-1:0]        lz;
  logic signed [EW-1:0]  lz_s, en_d;
  logic [MW-1:0]         mn_d;
  logic                  zero_d, rsign_d;

  fp_lzc #(.WIDTH(MW)) u_lzc (.din(sum_q[MW-1:0]), .cnt(lz));

  always_comb begin
    lz_s    = {{(EW-LZW){1'b0}}, lz};
    mn_d    = sum_q[MW-1:0] << lz;
    en_d    = ex_q - lz_s;
    zero_d  = 1'b0;
    rsign_d = sx_q;
    if (sum_q[MW]) begin
      // Carry: drop one bit to the right, folding it into sticky
      mn_d = {sum_q[MW:2], sum_q[1] | sum_q[0]};
      en_d = ex_q + ONE_S;
    end else if (sum_q == '0) begin
      zero_d  = 1'b1;
      rsign_d = sx_q & sy_q;             // only (-0)+(-0) keeps a negative zero
    end else if (en_d[EW-1] || en_d == '0) begin
      zero_d  = 1'b1;                    // underflow flushed to a signed zero
    end
  end

  // ---------------- ROUND and result assembly
  logic                 inc, ovf;
  logic [MAN_W+1:0]     rm;
  logic signed [EW-1:0] er;
  logic [MAN_W-1:0]     frac;
  logic [W-1:0]         result_d;
  logic [3:0]           flags_d;

  always_comb begin
    inc      = mn_q[2] & (mn_q[1] | mn_q[0] | mn_q[3]);
    rm       = {1'b0, mn_q[MW-1:3]} + {{(MAN_W+1){1'b0}}, inc};
    er       = rm[MAN_W+1] ? ex_q + ONE_S : ex_q;
    frac     = rm[MAN_W+1] ? rm[MAN_W:1] : rm[MAN_W-1:0];
    ovf      = (er >= EXP_INF);
    result_d = '0;
    flags_d  = '0;
    if (spec_q == CLS_NAN) begin
      result_d = QNAN_ALL[W-1:0];
    end else if (spec_q == CLS_INF) begin
      result_d = {spec_sign_q, EXP_MAX, {MAN_W{1'b0}}};
      flags_d[FLAG_N] = spec_sign_q;
    end else if (zero_q) begin
      result_d = {rsign_q, {(W-1){1'b0}}};
      flags_d[FLAG_N] = rsign_q;
      flags_d[FLAG_Z] = 1'b1;
    end else if (ovf) begin
      result_d = {rsign_q, EXP_MAX, {MAN_W{1'b0}}};
      flags_d[FLAG_N] = rsign_q;
      flags_d[FLAG_V] = 1'b1;
    end else begin
      result_d = {rsign_q, er[EXP_W-1:0], frac};
      flags_d[FLAG_N] = rsign_q;
      flags_d[FLAG_C] = carry_q;
    end
  end

  // ---------------- FSM
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (in_valid) state_d = ST_ALIGN;
      ST_ALIGN: state_d = ST_ADD;
      ST_ADD:   state_d = ST_NORM;
      ST_NORM:  state_d = ST_ROUND;
      ST_ROUND: state_d = ST_OUT;
      ST_OUT:   if (out_ready) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      a_q <= '0; b_q <= '0;
      spec_q <= CLS_NORM; spec_sign_q <= 1'b0;
      sx_q <= 1'b0; sy_q <= 1'b0; ex_q <= '0;
      mx_q <= '0; my_q <= '0; sum_q <= '0; carry_q <= 1'b0;
      mn_q <= '0; zero_q <= 1'b0; rsign_q <= 1'b0;
      result_q <= '0; flags_q <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        ST_IDLE: if (in_valid) begin
          a_q <= a;
          b_q <= b ^ {op_sub, {(W-1){1'b0}}};
        end
        ST_ALIGN: begin
          spec_q      <= spec_d;
          spec_sign_q <= (ca == CLS_INF) ? sa : sb;
          sx_q        <= a_ge_b ? sa : sb;
          sy_q        <= a_ge_b ? sb : sa;
          ex_q        <= {2'b00, xe};
          mx_q        <= {xm, 3'b000};
          my_q        <= my_d;
        end
        ST_ADD: begin
          sum_q   <= sum_d;
          carry_q <= ~(sx_q ^ sy_q) & sum_d[MW];
        end
        ST_NORM: begin
          mn_q    <= mn_d;
          ex_q    <= en_d;
          zero_q  <= zero_d;
          rsign_q <= rsign_d;
        end
        ST_ROUND: begin
          result_q <= result_d;
          flags_q  <= flags_d;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_addsub_seq.sv
module tb_fp_addsub_seq;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid = 1'b0, op_sub = 1'b0, out_ready = 1'b1;
  logic        in_ready, out_valid;
  logic [31:0] a = '0, b = '0, result;
  logic [3:0]  flags;
  int          n_cmp = 0, n_fail = 0;

  always #5 clk = ~clk;

  fp_addsub_seq #(.EXP_W(8), .MAN_W(23)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .op_sub(op_sub), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .flags(flags)
  );

  typedef struct {
    logic [31:0] a, b;
    logic        sub;
    logic [31:0] res;
    logic [3:0]  flg;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Exact-arithmetic reference: scale both significands to a common integer
  // grid, add exactly, then round the exact sum to 24 bits (nearest, ties even).
  // Handles normal and zero operands only.
  function automatic void ref_model(input logic [31:0] a_in, input logic [31:0] b_in,
                                    input logic sub, output logic [31:0] r, output logic [3:0] f);
    logic sa, sb, sgn, cy;
    int ea, eb, emin, emax, p, re, sh;
    logic [199:0] ma, mb, s, keep, rem, half;
    sa = a_in[31];
    sb = b_in[31] ^ sub;
    ea = int'(a_in[30:23]);
    eb = int'(b_in[30:23]);
    ma = (ea == 0) ? '0 : 200'({1'b1, a_in[22:0]});
    mb = (eb == 0) ? '0 : 200'({1'b1, b_in[22:0]});
    if (ma == 0 && mb == 0) begin
      r = {sa & sb, 31'h0};
      f = {sa & sb, 1'b1, 2'b00};
      return;
    end
    if (ma == 0) ea = eb;
    if (mb == 0) eb = ea;
    emin = (ea < eb) ? ea : eb;
    emax = (ea < eb) ? eb : ea;
    ma = ma << (ea - emin);
    mb = mb << (eb - emin);
    cy = 1'b0;
    if (sa == sb) begin
      s = ma + mb; sgn = sa;
      cy = (s >= (200'(1) << (24 + emax - emin)));
    end else if (ma >= mb) begin
      s = ma - mb; sgn = sa;
    end else begin
      s = mb - ma; sgn = sb;
    end
    if (s == 0) begin
      r = 32'h0; f = 4'b0100;
      return;
    end
    p = 0;
    for (int i = 0; i < 200; i++) if (s[i]) p = i;
    re = emin + p - 23;
    if (p > 23) begin
      sh   = p - 23;
      keep = s >> sh;
      rem  = s - (keep << sh);
      half = 200'(1) << (sh - 1);
      if (rem > half || (rem == half && keep[0])) keep = keep + 1;
      if (keep[24]) begin keep = keep >> 1; re++; end
    end else begin
      keep = s << (23 - p);
    end
    if (re >= 255)     begin r = {sgn, 8'hFF, 23'h0}; f = {sgn, 3'b001}; end
    else if (re <= 0)  begin r = {sgn, 31'h0};        f = {sgn, 3'b100}; end
    else               begin r = {sgn, 8'(re), keep[22:0]}; f = {sgn, 1'b0, cy, 1'b0}; end
  endfunction

  // Issue one op with out_ready high; returns result, flags and the edge count
  // from the accept edge (counted as 1) to the edge after which out_valid is seen.
  task automatic run_op(input logic [31:0] ta, input logic [31:0] tb_v, input logic sub,
                        output logic [31:0] r, output logic [3:0] f, output int lat);
    @(negedge clk);
    a = ta; b = tb_v; op_sub = sub; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    r = result; f = flags;
    if (!out_valid) begin
      n_cmp++; n_fail++;
      $display("FAIL timeout: out_valid never rose for %h op %h", ta, tb_v);
    end
    @(posedge clk); #1;   // handshake edge
  endtask

  initial begin
    vec_t        vt[14];
    logic [31:0] r, er, ra, rb;
    logic [3:0]  f, ef;
    int          lat;
    logic        seen;

    vt[0]  = '{32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 4'b0010};
    vt[1]  = '{32'h3FC00000, 32'h3FC00000, 1'b1, 32'h00000000, 4'b0100};
    vt[2]  = '{32'hBF800000, 32'h3F000000, 1'b0, 32'hBF000000, 4'b1000};
    vt[3]  = '{32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 4'b0000};
    vt[4]  = '{32'h3F800000, 32'h33C00000, 1'b0, 32'h3F800001, 4'b0000};
    vt[5]  = '{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 4'b0001};
    vt[6]  = '{32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 4'b0000};
    vt[7]  = '{32'h7FC00001, 32'h3F800000, 1'b0, 32'h7FC00000, 4'b0000};
    vt[8]  = '{32'hFF800000, 32'h3F800000, 1'b0, 32'hFF800000, 4'b1000};
    vt[9]  = '{32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 4'b1100};
    vt[10] = '{32'h00000001, 32'h3F800000, 1'b0, 32'h3F800000, 4'b0000};
    vt[11] = '{32'h3F800000, 32'h40000000, 1'b1, 32'hBF800000, 4'b1000};
    vt[12] = '{32'h00000000, 32'h00000000, 1'b1, 32'h00000000, 4'b0100};
    vt[13] = '{32'h40400000, 32'h40400000, 1'b0, 32'h40C00000, 4'b0010};

    // Reset state
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", {out_valid, in_ready, result, flags}, {1'b0, 1'b1, 32'h0, 4'h0});
    @(negedge clk) reset_n = 1'b1;

    // Directed vectors
    for (int i = 0; i < 14; i++) begin
      run_op(vt[i].a, vt[i].b, vt[i].sub, r, f, lat);
      chk($sformatf("vec%0d_result", i), r, vt[i].res);
      chk($sformatf("vec%0d_flags", i), f, vt[i].flg);
      if (i == 0) chk("latency", lat, 5);
    end

    // Backpressure: result held while out_ready low, busy in_valid ignored
    out_ready = 1'b0;
    @(negedge clk);
    a = 32'h3F800000; b = 32'h40000000; op_sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    chk("bp_first", {out_valid, result, flags}, {1'b1, 32'h40400000, 4'h0});
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      a = $urandom; b = $urandom; in_valid = 1'b1;
      @(posedge clk); #1;
      chk("bp_hold", {out_valid, in_ready, result, flags}, {1'b1, 1'b0, 32'h40400000, 4'h0});
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release", {out_valid, in_ready}, {1'b0, 1'b1});
    seen = 1'b0;
    repeat (8) begin @(posedge clk); #1; seen |= out_valid; end
    chk("bp_not_queued", seen, 1'b0);

    // Reset while the op is in NORM
    @(negedge clk);
    a = 32'h3F800000; b = 32'h3F800000; op_sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0;   // ALIGN
    @(posedge clk); #1;                    // ADD
    @(posedge clk); #1;                    // NORM
    reset_n = 1'b0;
    @(posedge clk); #1;
    chk("rst_mid", {out_valid, in_ready, result, flags}, {1'b0, 1'b1, 32'h0, 4'h0});
    @(negedge clk) reset_n = 1'b1;
    seen = 1'b0;
    repeat (8) begin @(posedge clk); #1; seen |= out_valid; end
    chk("rst_no_result", seen, 1'b0);
    run_op(32'h40000000, 32'h40000000, 1'b0, r, f, lat);
    chk("rst_next_result", r, 32'h40800000);
    chk("rst_next_flags", f, 4'b0010);
    chk("rst_next_latency", lat, 5);

    // Randomised normal operands against the exact-arithmetic model
    for (int i = 0; i < 200; i++) begin
      logic        sub;
      int          ea, eb, mode;
      ea   = $urandom_range(100, 150);
      mode = $urandom_range(0, 7);
      eb   = (mode < 3) ? ea : $urandom_range(100, 150);
      ra   = {1'($urandom_range(0, 1)), 8'(ea), 23'($urandom)};
      rb   = {1'($urandom_range(0, 1)), 8'(eb), 23'($urandom)};
      if (mode == 0) rb = ra;
      sub  = 1'($urandom_range(0, 1));
      ref_model(ra, rb, sub, er, ef);
      run_op(ra, rb, sub, r, f, lat);
      chk($sformatf("rnd%0d_result(%h,%h,%0d)", i, ra, rb, sub), r, er);
      chk($sformatf("rnd%0d_flags", i), f, ef);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
